mac_accum: RTL and testbench



---
 rtl/mac_accum_pkg.sv | 21 ++
 rtl/mac_accum_add.sv | 40 ++++
 rtl/rca_Nbit_co.sv | 24 ++
 rtl/mac_accum.sv | 113 +++++++++++
 tb/tb_mac_accum.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/mac_accum_pkg.sv
// Shared types and helpers for the mac_accum signed multiply-accumulate stage.
// FSM state encoding and signed saturation limits for any accumulator width up to 64 bits.
package mac_accum_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ACCUM = 2'd1,
      HOLD  = 2'd2
   } mac_state_t;

   // Largest positive two's-complement value of a w-bit word, zero-extended to 64 bits.
   function automatic logic [63:0] max_s(input int w);
      return (64'd1 << (w - 1)) - 64'd1;
   endfunction

   // Most negative w-bit value; callers truncate to w bits to get 1000...0.
   function automatic logic [63:0] min_s(input int w);
      return ~max_s(w);
   endfunction

endpackage

// File: rtl/mac_accum_add.sv
// Signed W-bit adder with overflow flag; clamps to the signed limits when MAC_ACCUM_SAT_EN is defined.
// Latency: combinational. Backpressure: none (pure datapath).
module mac_accum_add
   import mac_accum_pkg::*;
#(
   parameter int W = 13
) (
   input  logic signed [W-1:0] a,
   input  logic signed [W-1:0] b,
   output logic signed [W-1:0] sum,
   output logic                ovf
);

   logic [W-1:0] raw;
   logic         co_unused;

   rca_Nbit_co #(.N(W)) u_rca (
      .a  (a),
      .b  (b),
      .ci (1'b0),
      .s  (raw),
      .co (co_unused)
   );

   // Equal-sign operands yielding an opposite-sign result is the only way a signed add overflows.
   assign ovf = (a[W-1] == b[W-1]) && (raw[W-1] != a[W-1]);

`ifdef MAC_ACCUM_SAT_EN
   localparam logic [W-1:0] SAT_MAX = W'(max_s(W));
   localparam logic [W-1:0] SAT_MIN = W'(min_s(W));

   always_comb begin
      sum = raw;
      if (ovf) sum = a[W-1] ? SAT_MIN : SAT_MAX;
   end
`else
   assign sum = raw;
`endif

endmodule

// File: rtl/rca_Nbit_co.sv
// N-bit ripple-carry adder with carry-in and carry-out.
// Latency: combinational. Backpressure: none (pure datapath).
module rca_Nbit_co #(
   parameter int N = 8
) (
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         ci,
   output logic [N-1:0] s,
   output logic         co
);

   logic [N:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < N; i++) begin : g_bit
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[N];

endmodule

// File: rtl/mac_accum.sv
// Signed MAC stage: sums LEN products from the multiplier into an ACC_W-bit total (clamps if MAC_ACCUM_SAT_EN).
// Latency: total valid the cycle after the LENth accept; one product per cycle while accumulating.
// Backpressure: in_ready low outside ACCUM; total held stable in HOLD until out_ready.
module mac_accum
   import mac_accum_pkg::*;
#(
   parameter int N     = 4,
   parameter int M     = 5,
   parameter int P     = N + M,
   parameter int LEN   = 8,
   parameter int ACC_W = P + 4
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    start,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [P-1:0]     prod,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [ACC_W-1:0] acc_out,
   output logic                    ovf,
   output logic                    busy
);

   localparam int CNT_W = $clog2(LEN + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(LEN - 1);

   if (P != N + M) begin : g_bad_p
      $error("mac_accum: P must equal N+M");
   end
   if (ACC_W < P) begin : g_bad_acc_w
      $error("mac_accum: ACC_W must be at least P");
   end
   if (LEN < 1) begin : g_bad_len
      $error("mac_accum: LEN must be at least 1");
   end

   mac_state_t              state;
   logic [CNT_W-1:0]        count;
   logic signed [ACC_W-1:0] prod_ext;
   logic signed [ACC_W-1:0] sum;
   logic                    add_ovf;

   assign prod_ext = ACC_W'(prod);

   mac_accum_add #(.W(ACC_W)) u_add (
      .a   (acc_out),
      .b   (prod_ext),
      .sum (sum),
      .ovf (add_ovf)
   );

   // Handshake outputs are registered alongside the state so neither depends on in_valid or out_ready.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         acc_out   <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         in_ready  <= 1'b0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  state    <= ACCUM;
                  acc_out  <= '0;
                  count    <= '0;
                  ovf      <= 1'b0;
                  in_ready <= 1'b1;
                  busy     <= 1'b1;
               end
            end
            ACCUM: begin
               if (in_valid && in_ready) begin
                  acc_out <= sum;
                  ovf     <= ovf | add_ovf;
                  count   <= count + 1'b1;
                  if (count == LAST) begin
                     state     <= HOLD;
                     in_ready  <= 1'b0;
                     out_valid <= 1'b1;
                  end
               end
            end
            HOLD: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (start) begin
                     state    <= ACCUM;
                     acc_out  <= '0;
                     count    <= '0;
                     ovf      <= 1'b0;
                     in_ready <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               in_ready  <= 1'b0;
               out_valid <= 1'b0;
               busy      <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mac_accum.sv
// Directed bench for mac_accum: default instance (LEN=8, ACC_W=13) and a narrow one (LEN=2, ACC_W=9).
module tb_mac_accum;

   logic clk = 1'b0;
   logic rst_n;

   logic              a_start, a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_ovf, a_busy;
   logic signed [8:0]  a_prod;
   logic signed [12:0] a_acc_out;

   logic              b_start, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf, b_busy;
   logic signed [8:0] b_prod;
   logic signed [8:0] b_acc_out;

   int n_checks = 0;
   int n_errors = 0;

   always #5 clk = ~clk;

   mac_accum dut_a (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (a_start),
      .in_valid  (a_in_valid),
      .in_ready  (a_in_ready),
      .prod      (a_prod),
      .out_valid (a_out_valid),
      .out_ready (a_out_ready),
      .acc_out   (a_acc_out),
      .ovf       (a_ovf),
      .busy      (a_busy)
   );

   mac_accum #(.LEN(2), .ACC_W(9)) dut_b (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (b_start),
      .in_valid  (b_in_valid),
      .in_ready  (b_in_ready),
      .prod      (b_prod),
      .out_valid (b_out_valid),
      .out_ready (b_out_ready),
      .acc_out   (b_acc_out),
      .ovf       (b_ovf),
      .busy      (b_busy)
   );

   task automatic check(input string tag, input int act, input int exp_v);
      n_checks++;
      if (act !== exp_v) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, act, exp_v);
      end
   endtask

   // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0;
      a_start = 0; a_in_valid = 0; a_out_ready = 0; a_prod = '0;
      b_start = 0; b_in_valid = 0; b_out_ready = 0; b_prod = '0;
      #2;
      check("rst in_ready",  int'(a_in_ready), 0);
      check("rst out_valid", int'(a_out_valid), 0);
      check("rst acc_out",   int'(a_acc_out), 0);
      check("rst ovf",       int'(a_ovf), 0);
      check("rst busy",      int'(a_busy), 0);
      #1 rst_n = 1'b1;
      step();

      // Basic: 1..8 -> 36
      a_start = 1; step(); a_start = 0;
      check("basic in_ready after start", int'(a_in_ready), 1);
      check("basic busy", int'(a_busy), 1);
      for (int i = 1; i <= 8; i++) begin
         a_prod = 9'(i); a_in_valid = 1;
         step();
         if (i == 7) check("basic out_valid early", int'(a_out_valid), 0);
      end
      a_in_valid = 0;
      check("basic out_valid", int'(a_out_valid), 1);
      check("basic acc_out",   int'(a_acc_out), 36);
      check("basic ovf",       int'(a_ovf), 0);
      check("basic in_ready hold", int'(a_in_ready), 0);
      a_out_ready = 1; step(); a_out_ready = 0;
      check("basic drained out_valid", int'(a_out_valid), 0);
      check("basic idle busy", int'(a_busy), 0);

      // Mid-op reset after 3 beats, asserted away from any edge
      a_start = 1; step(); a_start = 0;
      for (int i = 0; i < 3; i++) begin
         a_prod = 9'sd5; a_in_valid = 1; step();
      end
      a_in_valid = 0;
      check("midop partial acc", int'(a_acc_out), 15);
      #2 rst_n = 1'b0;
      #1;
      check("midop rst acc_out",  int'(a_acc_out), 0);
      check("midop rst in_ready", int'(a_in_ready), 0);
      check("midop rst busy",     int'(a_busy), 0);
      #1 rst_n = 1'b1;
      step();
      a_start = 1; step(); a_start = 0;
      for (int i = 0; i < 8; i++) begin
         a_prod = -9'sd120; a_in_valid = 1; step();
      end
      a_in_valid = 0;
      check("midop acc_out", int'(a_acc_out), -960);
      check("midop ovf",     int'(a_ovf), 0);
      check("midop out_valid", int'(a_out_valid), 1);

      // Back-to-back: start with out_ready in HOLD
      a_start = 1; a_out_ready = 1; step(); a_start = 0; a_out_ready = 0;
      check("b2b in_ready",  int'(a_in_ready), 1);
      check("b2b out_valid", int'(a_out_valid), 0);
      check("b2b acc clear", int'(a_acc_out), 0);
      for (int i = 0; i < 8; i++) begin
         a_prod = -9'sd112; a_in_valid = 1; step();
      end
      a_in_valid = 0;
      check("b2b acc_out", int'(a_acc_out), -896);
      check("b2b ovf",     int'(a_ovf), 0);
      a_out_ready = 1; step(); a_out_ready = 0;

      // Backpressure on the LEN=2 instance: gapped input, stalled output
      b_start = 1; step(); b_start = 0;
      b_prod = 9'sd5; b_in_valid = 1; step(); b_in_valid = 0;
      step(); step();
      check("bp mid acc", int'(b_acc_out), 5);
      check("bp mid out_valid", int'(b_out_valid), 0);
      b_prod = -9'sd3; b_in_valid = 1; step(); b_in_valid = 0;
      step(); step();
      b_prod = 9'sd100; b_in_valid = 1;
      for (int i = 0; i < 5; i++) begin
         check("bp hold acc_out",   int'(b_acc_out), 2);
         check("bp hold in_ready",  int'(b_in_ready), 0);
         check("bp hold out_valid", int'(b_out_valid), 1);
         step();
      end
      check("bp extra beat not consumed", int'(b_acc_out), 2);
      b_in_valid = 0; b_out_ready = 1; step(); b_out_ready = 0;
      check("bp released", int'(b_out_valid), 0);

      // Overflow: 128 + 128 in 9 bits
      b_start = 1; step(); b_start = 0;
      for (int i = 0; i < 2; i++) begin
         b_prod = 9'sd128; b_in_valid = 1; step();
      end
      b_in_valid = 0;
`ifdef MAC_ACCUM_SAT_EN
      check("ovf acc_out sat", int'(b_acc_out), 255);
`else
      check("ovf acc_out wrap", int'(b_acc_out), -256);
`endif
      check("ovf flag", int'(b_ovf), 1);
      b_out_ready = 1; step(); b_out_ready = 0;
      check("ovf sticky in idle", int'(b_ovf), 1);
      b_start = 1; step(); b_start = 0;
      check("ovf cleared by start", int'(b_ovf), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
